// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: EX operand forwarding selects, load-use stall and saturating stall counter
module fwd_hazard_unit #(
  parameter int CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [4:0]       EX_Rs,
  input  logic [4:0]       EX_Rt,
  input  logic             EX_RegWrite,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_WriteReg,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  output logic [1:0]       FwdA,
  output logic [1:0]       FwdB,
  output logic             Stall,
  output logic [CNT_W-1:0] StallCount
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t state, state_nxt;
  logic mem_rw, mem_mr, wb_rw, hz, mem_ok, wb_ok;
  logic [4:0] mem_wr, wb_wr;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mem_rw     <= 1'b0;
      mem_mr     <= 1'b0;
      mem_wr     <= '0;
      wb_rw      <= 1'b0;
      wb_wr      <= '0;
      state      <= IDLE;
      StallCount <= '0;
    end else begin
      mem_rw     <= EX_RegWrite;
      mem_mr     <= EX_MemRead;
      mem_wr     <= EX_WriteReg;
      wb_rw      <= mem_rw;
      wb_wr      <= mem_wr;
      state      <= state_nxt;
      StallCount <= (Stall && StallCount != '1) ? StallCount + 1'b1 : StallCount;
    end
  end
  // a load sitting in MEM has no data yet, so it is never a forward source
  always_comb begin
    mem_ok = mem_rw && !mem_mr && mem_wr != 5'd0;
    wb_ok  = wb_rw && wb_wr != 5'd0;
    FwdA   = (mem_ok && mem_wr == EX_Rs) ? 2'b10 : (wb_ok && wb_wr == EX_Rs) ? 2'b01 : 2'b00;
    FwdB   = (mem_ok && mem_wr == EX_Rt) ? 2'b10 : (wb_ok && wb_wr == EX_Rt) ? 2'b01 : 2'b00;
    hz     = EX_MemRead && EX_WriteReg != 5'd0 && (EX_WriteReg == ID_Rs || EX_WriteReg == ID_Rt);
    Stall  = state == IDLE && hz;
    state_nxt = Stall ? HOLD : IDLE;
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: table-driven scoreboard bench for fwd_hazard_unit (CNT_W=32 and CNT_W=2)
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] ex_rs, ex_rt, ex_wr, id_rs, id_rt;
  logic ex_rw, ex_mr;
  logic [1:0] fa, fb, fa2, fb2;
  logic st, st2;
  logic [31:0] cnt;
  logic [1:0] cnt2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.CNT_W(32)) dut (
    .Clk(clk), .Reset(rst), .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_RegWrite(ex_rw),
    .EX_MemRead(ex_mr), .EX_WriteReg(ex_wr), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .FwdA(fa), .FwdB(fb), .Stall(st), .StallCount(cnt)
  );

  fwd_hazard_unit #(.CNT_W(2)) dut2 (
    .Clk(clk), .Reset(rst), .EX_Rs(ex_rs), .EX_Rt(ex_rt), .EX_RegWrite(ex_rw),
    .EX_MemRead(ex_mr), .EX_WriteReg(ex_wr), .ID_Rs(id_rs), .ID_Rt(id_rt),
    .FwdA(fa2), .FwdB(fb2), .Stall(st2), .StallCount(cnt2)
  );

  typedef struct {
    logic rst;
    logic [4:0] rs, rt;
    logic rw, mr;
    logic [4:0] wr, irs, irt;
    logic [1:0] fa, fb;
    logic st;
    logic [31:0] c;
    logic [1:0] s;
    logic chk;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];

  function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic rw, logic mr,
                              logic [4:0] wr, logic [4:0] irs, logic [4:0] irt, logic [1:0] efa,
                              logic [1:0] efb, logic est, logic [31:0] ec, logic [1:0] es, logic chk);
    vec_t v;
    v.rst = r; v.rs = rs; v.rt = rt; v.rw = rw; v.mr = mr; v.wr = wr; v.irs = irs; v.irt = irt;
    v.fa = efa; v.fb = efb; v.st = est; v.c = ec; v.s = es; v.chk = chk;
    return v;
  endfunction

  function automatic logic [1:0] sat3(int x);
    return (x > 3) ? 2'd3 : 2'(x);
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp, int row);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
    end
  endtask

  task automatic run(vec_t v, int row);
    vec_t e;
    @(posedge clk);
    #1;
    rst = v.rst; ex_rs = v.rs; ex_rt = v.rt; ex_rw = v.rw; ex_mr = v.mr;
    ex_wr = v.wr; id_rs = v.irs; id_rt = v.irt;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    if (e.chk) begin
      cmp("FwdA", 32'(fa), 32'(e.fa), row);
      cmp("FwdB", 32'(fb), 32'(e.fb), row);
      cmp("Stall", 32'(st), 32'(e.st), row);
      cmp("StallCount", cnt, e.c, row);
      cmp("StallCount_w2", 32'(cnt2), 32'(e.s), row);
      cmp("Stall_w2", 32'(st2), 32'(e.st), row);
    end
  endtask

  initial begin
    rst = 1'b1; ex_rs = '0; ex_rt = '0; ex_rw = 1'b0; ex_mr = 1'b0;
    ex_wr = '0; id_rs = '0; id_rt = '0;
    tbl.push_back(mk(1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 5, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 5, 0, 1, 0, 8, 0, 0, 2, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8, 5, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8, 1, 0, 3, 0, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8, 3, 1, 0, 3, 0, 0, 0, 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 3, 3, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 0, 9, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 9, 0, 9, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 9, 9, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 7, 7, 0, 0, 0, 1, 1, 1, 1));
    tbl.push_back(mk(1, 0, 0, 1, 1, 7, 7, 0, 0, 0, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 0, 1, 1, 7, 7, 0, 0, 0, 1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    for (int k = 0; k < 5; k++) begin
      tbl.push_back(mk(0, 0, 0, 1, 1, 4, 4, 0, 0, 0, 1, 32'(1 + k), sat3(1 + k), 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'(2 + k), sat3(2 + k), 1));
    end
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 6, 3, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 3, 1));
    foreach (tbl[i]) run(tbl[i], i);
    // hand sequence: a held load keeps re-stalling only every other cycle
    run(mk(0, 0, 0, 1, 1, 6, 0, 6, 0, 0, 1, 6, 3, 1), 100);
    run(mk(0, 0, 0, 1, 1, 6, 0, 6, 0, 0, 0, 7, 3, 1), 101);
    run(mk(0, 0, 0, 1, 1, 6, 0, 6, 0, 0, 1, 7, 3, 1), 102);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 3, 1), 103);
    run(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 3, 0), 104);
    run(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 105);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
